// File: rtl/debounced_event_counter.sv
// debounced_event_counter: per-channel synchroniser, debounce FSM and wrap/saturate up/down counter; `DBC_AUTO_REPEAT_EN adds hold-to-repeat presses
module debounced_event_counter #(
    parameter int CHANNELS        = 4,
    parameter int WIDTH           = 4,
    parameter int MAX_COUNT       = 15,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       inp,
    input  logic [CHANNELS-1:0]       dir,
    input  logic                      sat,
    input  logic [CHANNELS-1:0]       clr,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       press,
    output logic [CHANNELS-1:0]       tc
);
    localparam int SW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SW-1:0] LAST = SW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX_COUNT);
    localparam logic SKIP = DEBOUNCE_CYCLES == 1;
`ifdef DBC_AUTO_REPEAT_EN
    localparam int HW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
    localparam logic [HW-1:0] FIRST = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] NEXT = HW'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    if (CHANNELS < 1 || WIDTH < 1 || MAX_COUNT < 1 || MAX_COUNT > 2**WIDTH - 1 ||
        DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("debounced_event_counter: parameter out of range");
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : ch
        logic s1, s2, pr, tr, bound;
        state_t st;
        logic [SW-1:0] stab;
        logic [WIDTH-1:0] cnt, nxt;
`ifdef DBC_AUTO_REPEAT_EN
        logic [HW-1:0] hold;
        logic rep;
`endif

        assign count[g*WIDTH +: WIDTH] = cnt;
        assign press[g] = pr;
        assign tc[g] = tr;

        // two-flop synchroniser for the asynchronous pin
        always_ff @(posedge clk or posedge rst) begin
            if (rst) {s2, s1} <= 2'b00;
            else {s2, s1} <= {s1, inp[g]};
        end

        // debounce FSM: an edge is accepted after DEBOUNCE_CYCLES consecutive agreeing samples
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st   <= IDLE;
                stab <= '0;
                pr   <= 1'b0;
`ifdef DBC_AUTO_REPEAT_EN
                hold <= '0;
                rep  <= 1'b0;
`endif
            end else begin
                pr <= 1'b0;
                case (st)
                    IDLE: if (s2) begin
                        st   <= SKIP ? HELD : PRESS_WAIT;
                        stab <= SKIP ? '0 : SW'(1);
                        pr   <= SKIP;
                    end
                    PRESS_WAIT: if (!s2) begin
                        st   <= IDLE;
                        stab <= '0;
                    end else if (stab >= LAST) begin
                        st   <= HELD;
                        stab <= '0;
                        pr   <= 1'b1;
                    end else stab <= stab + 1'b1;
                    HELD: if (!s2) begin
                        st   <= SKIP ? IDLE : RELEASE_WAIT;
                        stab <= SKIP ? '0 : SW'(1);
`ifdef DBC_AUTO_REPEAT_EN
                        hold <= '0;
                        rep  <= 1'b0;
                    end else if (hold >= (rep ? NEXT : FIRST)) begin
                        pr   <= 1'b1;
                        hold <= '0;
                        rep  <= 1'b1;
                    end else hold <= hold + 1'b1;
`else
                    end
`endif
                    RELEASE_WAIT: if (s2) begin
                        st   <= HELD;
                        stab <= '0;
                    end else if (stab >= LAST) begin
                        st   <= IDLE;
                        stab <= '0;
                    end else stab <= stab + 1'b1;
                endcase
            end
        end

        // step result: at a bound, wrap-up and saturate-down give 0, the other two give TOP
        always_comb begin
            bound = dir[g] ? (cnt == '0) : (cnt >= TOP);
            nxt   = !bound ? (dir[g] ? cnt - 1'b1 : cnt + 1'b1) : ((dir[g] ^ sat) ? TOP : '0);
        end

        // counter register: clear beats a coincident step, tc flags a step taken at a bound
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                tr  <= 1'b0;
            end else begin
                tr <= !clr[g] && pr && bound;
                if (clr[g]) cnt <= '0;
                else if (pr) cnt <= nxt;
            end
        end
    end
endmodule

// File: tb/tb_debounced_event_counter.sv
// tb_debounced_event_counter: directed scenarios plus random bouncing inputs checked against a run-length reference model
module tb_debounced_event_counter;
    localparam int CH = 2, W = 4, MX = 9, DB = 4, RD = 20, RP = 5;

    logic clk = 1'b0, rst = 1'b1, sat = 1'b0;
    logic [CH-1:0] inp = '0, dir = '0, clr = '0;
    logic [CH*W-1:0] count;
    logic [CH-1:0] press, tc;
    int checks = 0, errors = 0;
    int np0 = 0, nt0 = 0;

    debounced_event_counter #(
        .CHANNELS(CH), .WIDTH(W), .MAX_COUNT(MX), .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .inp(inp), .dir(dir), .sat(sat), .clr(clr),
        .count(count), .press(press), .tc(tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: synced level is the pin two edges late; an accepted level flips after
    // DB consecutive disagreeing samples; a press is seen one edge after acceptance and
    // is applied to the count on the edge after that
    bit ms1[CH], ms2[CH], mpress[CH], mtc[CH];
    int acc[CH], run[CH], held_for[CH], mcnt[CH];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                ms1[c] = 0; ms2[c] = 0; mpress[c] = 0; mtc[c] = 0;
                acc[c] = 0; run[c] = 0; held_for[c] = 0; mcnt[c] = 0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (clr[c]) begin
                    mcnt[c] = 0; mtc[c] = 0;
                end else if (mpress[c]) begin
                    if (!dir[c]) begin
                        mtc[c] = mcnt[c] >= MX;
                        mcnt[c] = mcnt[c] < MX ? mcnt[c] + 1 : (sat ? MX : 0);
                    end else begin
                        mtc[c] = mcnt[c] == 0;
                        mcnt[c] = mcnt[c] > 0 ? mcnt[c] - 1 : (sat ? 0 : MX);
                    end
                end else mtc[c] = 0;
                mpress[c] = 0;
                if (int'(ms2[c]) != acc[c]) begin
                    run[c]++;
                    held_for[c] = 0;
                    if (run[c] == DB) begin
                        acc[c] = int'(ms2[c]);
                        run[c] = 0;
                        mpress[c] = ms2[c];
                    end
                end else begin
                    if (acc[c] == 1 && run[c] == 0) begin
                        held_for[c]++;
`ifdef DBC_AUTO_REPEAT_EN
                        if (held_for[c] == RD || (held_for[c] > RD && (held_for[c] - RD) % RP == 0))
                            mpress[c] = 1;
`endif
                    end else held_for[c] = 0;
                    run[c] = 0;
                end
                ms2[c] = ms1[c];
                ms1[c] = inp[c];
            end
        end
    end

    // compare every cycle, after the edge has settled
    always @(posedge clk) begin
        logic [31:0] ec;
        logic [CH-1:0] ep, et;
        #2;
        if (!rst) begin
            ec = '0;
            for (int c = 0; c < CH; c++) begin
                ec |= 32'(mcnt[c]) << (c * W);
                ep[c] = mpress[c];
                et[c] = mtc[c];
            end
            check("count", 32'(count), ec);
            check("press", 32'(press), 32'(ep));
            check("tc", 32'(tc), 32'(et));
            np0 += int'(press[0]);
            nt0 += int'(tc[0]);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(input int c);
        @(negedge clk);
        inp[c] = 1'b1;
        cycles(8);
        inp[c] = 1'b0;
        cycles(8);
    endtask

    task automatic clear(input int c);
        @(negedge clk);
        clr[c] = 1'b1;
        @(negedge clk);
        clr[c] = 1'b0;
    endtask

    task automatic ccount(input string tag, input int c, input int exp);
        check(tag, 32'(count[c*W +: W]), 32'(exp));
    endtask

    task automatic press_timing(input string tag);
        for (int e = 0; e < 9; e++) begin
            @(posedge clk);
            #2;
            check(tag, 32'(press[0]), 32'(e == 5));
        end
    endtask

    task automatic zero_outputs(input string tag);
        check({tag, "_count"}, 32'(count), 32'(0));
        check({tag, "_press"}, 32'(press), 32'(0));
        check({tag, "_tc"}, 32'(tc), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, t, exp_rep;
        logic found;
        cycles(3);
        zero_outputs("reset");
        rst = 1'b0;
        cycles(2);
        // clean press on ch0
        @(negedge clk);
        inp[0] = 1'b1;
        press_timing("t1_press");
        ccount("t1_cnt0", 0, 1);
        ccount("t1_cnt1", 1, 0);
        cycles(2);
        inp[0] = 1'b0;
        cycles(10);
        // bounce on press and on release
        p = np0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            inp[0] = (i % 2 == 0);
        end
        @(negedge clk);
        inp[0] = 1'b1;
        cycles(10);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            inp[0] = (i % 2 == 1);
        end
        @(negedge clk);
        inp[0] = 1'b0;
        cycles(10);
        check("t2_presses", 32'(np0 - p), 32'(1));
        ccount("t2_cnt", 0, 2);
        // wrap and saturate
        clear(0);
        t = nt0;
        for (int i = 0; i < 10; i++) begin
            tap(0);
            ccount("t3_wrap", 0, (i + 1) % 10);
            if (i == 8) check("t3_tc_none", 32'(nt0 - t), 32'(0));
        end
        check("t3_tc_wrap", 32'(nt0 - t), 32'(1));
        for (int i = 0; i < 9; i++) tap(0);
        ccount("t3_at9", 0, 9);
        sat = 1'b1;
        t = nt0;
        tap(0);
        ccount("t3_sat_hi", 0, 9);
        check("t3_sat_hi_tc", 32'(nt0 - t), 32'(1));
        clear(0);
        dir[0] = 1'b1;
        t = nt0;
        tap(0);
        ccount("t3_sat_lo", 0, 0);
        check("t3_sat_lo_tc", 32'(nt0 - t), 32'(1));
        // down wrap, then clear coinciding with a step
        sat = 1'b0;
        t = nt0;
        tap(0);
        ccount("t4_down_wrap", 0, 9);
        check("t4_down_wrap_tc", 32'(nt0 - t), 32'(1));
        @(negedge clk);
        inp[0] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #2;
            found = press[0];
        end
        check("t4_press_seen", 32'(found), 32'(1));
        clr[0] = 1'b1;
        @(posedge clk);
        #2;
        ccount("t4_clr_cnt", 0, 0);
        check("t4_clr_tc", 32'(tc[0]), 32'(0));
        @(negedge clk);
        clr[0] = 1'b0;
        inp[0] = 1'b0;
        dir[0] = 1'b0;
        cycles(10);
        // async reset during PRESS_WAIT and during HELD
        tap(1);
        tap(1);
        ccount("t5_ch1", 1, 2);
        @(negedge clk);
        inp[0] = 1'b1;
        cycles(3);
        rst = 1'b1;
        #1;
        zero_outputs("t5_rst_pw");
        cycles(2);
        rst = 1'b0;
        press_timing("t5_pw_press");
        ccount("t5_pw_cnt", 0, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        zero_outputs("t5_rst_held");
        cycles(2);
        rst = 1'b0;
        press_timing("t5_held_press");
        @(negedge clk);
        inp[0] = 1'b0;
        cycles(10);
        // long hold
        clear(0);
        p = np0;
        @(negedge clk);
        inp[0] = 1'b1;
        cycles(42);
        inp[0] = 1'b0;
        cycles(10);
`ifdef DBC_AUTO_REPEAT_EN
        exp_rep = 5;
`else
        exp_rep = 1;
`endif
        check("t6_presses", 32'(np0 - p), 32'(exp_rep));
        ccount("t6_cnt", 0, exp_rep);
        // random bouncing inputs, clears, directions and mode
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(5) == 0) inp[c] = ~inp[c];
                clr[c] = ($urandom_range(39) == 0);
                if ($urandom_range(99) == 0) dir[c] = 1'($urandom_range(1));
            end
            if ($urandom_range(199) == 0) sat = ~sat;
        end
        @(negedge clk);
        inp = '0;
        clr = '0;
        cycles(12);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
